dac_frame_sched: RTL and testbench
==================================

// Module: dac_frame_sched
// PURPOSE
//  Frame scheduler for the 2-channel SPI DAC (MCP4912-style 16-bit command word) behind dac_spi.
//  Paces updates at SAMPLE_HZ and takes one sample per channel per frame via valid/ready.
//  Issues two dac_spi transfers per frame (A then B), then pulses ldac_n so both outputs move together.
//  Sits between the DDS sample sources and dac_spi; it is the only driver of dac_spi start/data.
// PARAMETERS
//  CLK_HZ      12_000_000  system clock frequency
//  SAMPLE_HZ   20_000      frame rate; DIV = CLK_HZ/SAMPLE_HZ clocks per frame, DIV >= 2
//  GAIN_2X     1           1: GA_n=0 (2x gain); 0: GA_n=1 (1x gain)
//  CS_TIMEOUT  64          max clocks from spi_start until spi_cs must go low
//  LDAC_CYCLES 4           ldac_n low-pulse width in clocks
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous, active-low reset
//  en         in   1   1: frames run; 0: ticks ignored, an in-flight frame completes
//  a_valid    in   1   channel A sample available
//  a_data     in   10  channel A sample, unsigned
//  a_ready    out  1   one-cycle accept pulse for channel A
//  b_valid    in   1   channel B sample available
//  b_data     in   10  channel B sample, unsigned
//  b_ready    out  1   one-cycle accept pulse for channel B
//  spi_start  out  1   one-cycle transfer request to dac_spi
//  spi_data   out  16  command word to dac_spi
//  spi_cs     in   1   dac_spi chip select, active low; low = transfer in progress
//  ldac_n     out  1   DAC latch strobe, active low
//  clr_flags  in   1   synchronous clear of overrun and spi_err
//  overrun    out  1   sticky: a tick arrived while a frame was still in progress
//  spi_err    out  1   sticky: spi_cs did not go low within CS_TIMEOUT
// BEHAVIOUR
//  Reset values: a_ready=b_ready=spi_start=0, spi_data=16'h0000, ldac_n=1, overrun=spi_err=0,
//   held samples hold_a=hold_b=10'h000, state IDLE, tick counter 0.
//  Tick: free-running counter 0..DIV-1. tick=1 for one cycle when count==DIV-1, then wraps to 0.
//   Counts regardless of en.
//  Word: {ch, 1'b0 (BUF), ~GAIN_2X, 1'b1 (SHDN_n), hold_x, 2'b00}; ch is 0 for A, 1 for B.
//   Default A word for sample 10'h200 is 16'h1800.
//  FSM:
//   IDLE: on tick & en -> CAPTURE.
//   CAPTURE (1 clk): for each channel, if x_valid then hold_x<=x_data and x_ready=1 this cycle;
//    otherwise hold_x keeps its last value (the sample repeats). -> START_A.
//   START_A: spi_data<=word(A), spi_start=1 for one clk -> WLO_A.
//   WLO_A: wait for spi_cs==0 -> WHI_A. If the wait counter reaches CS_TIMEOUT:
//    spi_err<=1 and go to IDLE (frame aborted, no ldac).
//   WHI_A: wait for spi_cs==1 -> START_B. No timeout here; dac_spi guarantees completion.
//   START_B, WLO_B, WHI_B: same as the A states for channel B -> LDAC.
//   LDAC: ldac_n=0 for LDAC_CYCLES clks -> IDLE.
//  spi_data stays stable from START_x through WHI_x.
//  First spi_start is 2 clks after tick (CAPTURE, then START_A).
//  Overrun: tick while state!=IDLE -> overrun<=1, tick dropped, current frame unaffected.
//  Simultaneous events: if clr_flags and a set condition coincide, set wins.
//   If en falls mid-frame, the frame completes.
//  rst_n low mid-frame: everything returns to reset values immediately.
//   spi_start is never left high; ldac_n is forced to 1.
//  Ready pulses occur only in CAPTURE. Sources must hold valid/data until ready is seen.
// STRUCTURE
//  Shared include dac_defs.vh: command bit positions (CH=15, BUF=14, GA_N=13, SHDN_N=12),
//   data field [11:2], FSM state encodings.
//  Sub-module rate_tick #(CLK_HZ, SAMPLE_HZ) (clk, rst_n, tick); counter width $clog2(DIV).
//  Everything else (FSM, hold regs, timeout/ldac counter, flags) lives in this module,
//   with one shared wait counter.
// TESTING (bench models dac_spi: cs low 2 clks after start, for 17 clks)
//  1. a_valid=1 a_data=200h, b_valid=1 b_data=3FFh, one tick -> spi_data 1800h then 9FFCh,
//     one a_ready and one b_ready pulse, then ldac_n low 4 clks.
//  2. b_valid=0 in frame 2 -> frame 2 resends the previous B word, b_ready stays 0, a_ready pulses.
//  3. Model never drops cs -> after 64 clks spi_err=1, no second start, ldac_n stays 1;
//     clr_flags clears it and the next tick runs normally.
//  4. SAMPLE_HZ set so DIV < frame length -> overrun=1, every frame still completes A, B, ldac in order.
//  5. Assert rst_n during WHI_B -> all outputs at reset values asynchronously;
//     resumes cleanly at the next tick after release.
//  6. en=0 across 3 ticks -> no spi_start and no ready pulses; en=1 -> frame starts on the next tick.

Source files
------------

// File: rtl/dac_frame_sched_pkg.sv
// Shared definitions for the 2-channel SPI DAC frame scheduler.
// Covers the command word bit positions, the FSM state encoding and the command word builder.
// There is no logic here, so it adds no latency and no flow control.
package dac_frame_sched_pkg;

  // Bit positions in the 16-bit MCP4912-style command word.
  localparam int CMD_CH     = 15;
  localparam int CMD_BUF    = 14;
  localparam int CMD_GA_N   = 13;
  localparam int CMD_SHDN_N = 12;
  localparam int DATA_MSB   = 11;
  localparam int DATA_LSB   = 2;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CAPTURE = 4'd1,
    ST_START_A = 4'd2,
    ST_WLO_A   = 4'd3,
    ST_WHI_A   = 4'd4,
    ST_START_B = 4'd5,
    ST_WLO_B   = 4'd6,
    ST_WHI_B   = 4'd7,
    ST_LDAC    = 4'd8
  } state_e;

  // Build a command word. The buffer is always off and the channel is never shut down.
  function automatic logic [15:0] dac_word(input logic       ch,
                                           input logic       gain_2x,
                                           input logic [9:0] sample);
    logic [15:0] w;
    w                     = '0;
    w[CMD_CH]             = ch;
    w[CMD_BUF]            = 1'b0;
    w[CMD_GA_N]           = ~gain_2x;
    w[CMD_SHDN_N]         = 1'b1;
    w[DATA_MSB:DATA_LSB]  = sample;
    return w;
  endfunction

endpackage

// File: rtl/dac_frame_sched_rate_tick.sv
// Frame-rate pacer: one-cycle tick every CLK_HZ/SAMPLE_HZ clocks. It is free-running and ignores enables.
// Latency: the first tick comes DIV-1 clocks after reset release, and every DIV clocks after that.
// Backpressure: none. Nobody can stall the tick, so a late consumer sees the pulse as dropped.
// Ports: clk, rst_n (async active-low), tick (out, 1 clk pulse when count == DIV-1).
module rate_tick #(
  parameter int CLK_HZ    = 12_000_000,
  parameter int SAMPLE_HZ = 20_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    tick    = (count_q == LAST);
    count_d = tick ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dac_frame_sched.sv
// Frame scheduler for a 2-channel SPI DAC. Each frame sends one A word and one B word to dac_spi, then pulses ldac_n.
// Latency: a_ready/b_ready 1 clk after tick, and the first spi_start 2 clks after tick.
// Backpressure: samples are taken only in CAPTURE, and a missing sample repeats the held value.
// A tick that arrives mid-frame is dropped and flagged as overrun.
// Ports: clk, rst_n (async active-low), en; a_/b_ valid/data/ready (sample inputs);
//        spi_start/spi_data/spi_cs (dac_spi handshake); ldac_n (latch strobe);
//        clr_flags, overrun, spi_err (sticky status).
module dac_frame_sched
  import dac_frame_sched_pkg::*;
#(
  parameter int CLK_HZ      = 12_000_000,
  parameter int SAMPLE_HZ   = 20_000,
  parameter int GAIN_2X     = 1,
  parameter int CS_TIMEOUT  = 64,
  parameter int LDAC_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        a_valid,
  input  logic [9:0]  a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [9:0]  b_data,
  output logic        b_ready,
  output logic        spi_start,
  output logic [15:0] spi_data,
  input  logic        spi_cs,
  output logic        ldac_n,
  input  logic        clr_flags,
  output logic        overrun,
  output logic        spi_err
);

  // One counter serves both the cs-low timeout and the ldac pulse width. The two never overlap.
  localparam int CNT_MAX = (CS_TIMEOUT > LDAC_CYCLES) ? CS_TIMEOUT : LDAC_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CS_LAST   = CNT_W'(CS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_CYCLES - 1);
  localparam logic             GAIN_BIT  = (GAIN_2X != 0);

  state_e            state_q, state_d;
  logic [9:0]        hold_a_q, hold_a_d;
  logic [9:0]        hold_b_q, hold_b_d;
  logic [15:0]       spi_data_q, spi_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              overrun_q, overrun_d;
  logic              spi_err_q, spi_err_d;
  logic              tick;
  logic              err_set;

  rate_tick #(
    .CLK_HZ    (CLK_HZ),
    .SAMPLE_HZ (SAMPLE_HZ)
  ) u_rate_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    hold_a_d   = hold_a_q;
    hold_b_d   = hold_b_q;
    spi_data_d = spi_data_q;
    cnt_d      = cnt_q;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    spi_start  = 1'b0;
    ldac_n     = 1'b1;
    err_set    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tick && en) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (a_valid) begin
          hold_a_d = a_data;
          a_ready  = 1'b1;
        end
        if (b_valid) begin
          hold_b_d = b_data;
          b_ready  = 1'b1;
        end
        // Load the word one clock early so that it is already on spi_data when spi_start fires.
        spi_data_d = dac_word(1'b0, GAIN_BIT, hold_a_d);
        state_d    = ST_START_A;
      end
      ST_START_A: begin
        spi_start = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WLO_A;
      end
      ST_WLO_A: begin
        if (!spi_cs) begin
          state_d = ST_WHI_A;
        end else if (cnt_q == CS_LAST) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WHI_A: begin
        if (spi_cs) begin
          spi_data_d = dac_word(1'b1, GAIN_BIT, hold_b_q);
          state_d    = ST_START_B;
        end
      end
      ST_START_B: begin
        spi_start = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WLO_B;
      end
      ST_WLO_B: begin
        if (!spi_cs) begin
          state_d = ST_WHI_B;
        end else if (cnt_q == CS_LAST) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WHI_B: begin
        if (spi_cs) begin
          cnt_d   = '0;
          state_d = ST_LDAC;
        end
      end
      ST_LDAC: begin
        ldac_n = 1'b0;
        if (cnt_q == LDAC_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Sticky flags. A set condition in the same clock as clr_flags wins.
    overrun_d = overrun_q;
    if (clr_flags) overrun_d = 1'b0;
    if (tick && (state_q != ST_IDLE)) overrun_d = 1'b1;

    spi_err_d = spi_err_q;
    if (clr_flags) spi_err_d = 1'b0;
    if (err_set) spi_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      spi_data_q <= '0;
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
      spi_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_a_q   <= hold_a_d;
      hold_b_q   <= hold_b_d;
      spi_data_q <= spi_data_d;
      cnt_q      <= cnt_d;
      overrun_q  <= overrun_d;
      spi_err_q  <= spi_err_d;
    end
  end

  assign spi_data = spi_data_q;
  assign overrun  = overrun_q;
  assign spi_err  = spi_err_q;

endmodule

// File: tb/tb_dac_frame_sched.sv
// Bench for dac_frame_sched. It drives random samples and models dac_spi chip-select.
// A reference model schedules the expected words, ready pulses, ldac windows and flags.
// One negedge monitor pops and compares everything the DUT presents.
module tb_dac_frame_sched;

  localparam int CLK_HZ      = 12_000_000;
  localparam int SAMPLE_HZ   = 200_000;
  localparam int DIV         = CLK_HZ / SAMPLE_HZ;   // 60 clocks per frame slot
  localparam int GAIN_2X     = 1;
  localparam int CS_TIMEOUT  = 64;
  localparam int LDAC_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [9:0]  a_data = '0, b_data = '0;
  logic        spi_cs = 1'b1;
  logic        clr_flags = 1'b0;
  logic        a_ready, b_ready, spi_start, ldac_n, overrun, spi_err;
  logic [15:0] spi_data;

  dac_frame_sched #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .GAIN_2X(GAIN_2X),
    .CS_TIMEOUT(CS_TIMEOUT), .LDAC_CYCLES(LDAC_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .spi_start(spi_start), .spi_data(spi_data), .spi_cs(spi_cs),
    .ldac_n(ldac_n), .clr_flags(clr_flags), .overrun(overrun), .spi_err(spi_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { int cyc; logic [15:0] word; } wexp_t;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: the cycle in which each event is due.
  wexp_t word_q[$];
  int    a_q[$];
  int    b_q[$];
  int    ldac_q[$];

  // Reference model state (cycle = clock edges since reset release).
  int         cyc = 0;
  bit         was_rst = 1'b1;
  int         frame_tick = -1;
  int         busy_until = 0;
  int         cap_cyc = -1;
  int         err_cyc = -1;
  logic [9:0] m_hold_a = '0, m_hold_b = '0;
  bit         exp_ovr = 1'b0, exp_err = 1'b0;
  bit         ldac_prev = 1'b1;
  int         ldac_lo = 0;
  int         b_starts = 0;

  // dac_spi model controls (written by stimulus only while the DUT is drained).
  int cs_len = 17;
  bit cs_never = 1'b0;
  int s_cyc = -1000;

  // Handshake from stimulus to monitor.
  bit done = 1'b0;
  bit b_rst_done = 1'b0;

  function automatic logic [15:0] exp_word(input int ch, input int sample);
    int v;
    v = ch * 32768 + (GAIN_2X != 0 ? 0 : 8192) + 4096 + sample * 4;
    return 16'(v);
  endfunction

  task automatic cmpi(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic miss(input string name, input int due);
    checks++;
    errors++;
    $display("FAIL %s cycle=%0d event due at cycle %0d never seen", name, cyc, due);
  endtask

  task automatic unexpected(input string name, input int got);
    checks++;
    errors++;
    $display("FAIL %s cycle=%0d got event (value %0h) expected none", name, cyc, got);
  endtask

  task automatic model_clear();
    word_q.delete(); a_q.delete(); b_q.delete(); ldac_q.delete();
    frame_tick = -1; busy_until = 0; cap_cyc = -1; err_cyc = -1;
    m_hold_a = '0; m_hold_b = '0; exp_ovr = 1'b0; exp_err = 1'b0;
    ldac_prev = 1'b1; ldac_lo = 0; s_cyc = -1000;
  endtask

  always @(negedge clk) begin : mon
    wexp_t we;
    bit    tk, busy, ovr_set;
    int    due;
    if (!rst_n) begin
      was_rst = 1'b1;
      spi_cs  = 1'b1;
      model_clear();
      cmpi("rst_spi_start", int'(spi_start), 0);
      cmpi("rst_a_ready",   int'(a_ready),   0);
      cmpi("rst_b_ready",   int'(b_ready),   0);
      cmpi("rst_ldac_n",    int'(ldac_n),    1);
      cmpi("rst_overrun",   int'(overrun),   0);
      cmpi("rst_spi_err",   int'(spi_err),   0);
      cmpi("rst_spi_data",  int'(spi_data),  0);
    end else begin
      if (was_rst) begin
        cyc = 0;
        was_rst = 1'b0;
      end else begin
        cyc++;
      end

      // dac_spi: cs low from 2 clocks after start, for cs_len clocks.
      if (spi_start) s_cyc = cyc;
      spi_cs = (cs_never || cyc < s_cyc + 2 || cyc > s_cyc + 1 + cs_len) ? 1'b1 : 1'b0;

      // Reference model: frame timing follows from the dac_spi handshake lengths.
      tk      = (cyc % DIV) == DIV - 1;
      busy    = (cyc > frame_tick) && (cyc < busy_until);
      ovr_set = tk && busy;
      if (tk && !busy && en) begin
        frame_tick = cyc;
        cap_cyc    = cyc + 1;
        if (cs_never) begin
          busy_until = cyc + 3 + CS_TIMEOUT;
          err_cyc    = cyc + 2 + CS_TIMEOUT;
        end else begin
          busy_until = cyc + 2 + 2 * (cs_len + 3) + LDAC_CYCLES;
        end
      end
      if (cyc == cap_cyc) begin
        if (a_valid) begin m_hold_a = a_data; a_q.push_back(cyc); end
        if (b_valid) begin m_hold_b = b_data; b_q.push_back(cyc); end
        word_q.push_back('{cyc: cyc + 1, word: exp_word(0, int'(m_hold_a))});
        if (!cs_never) begin
          word_q.push_back('{cyc: cyc + 1 + cs_len + 3, word: exp_word(1, int'(m_hold_b))});
          ldac_q.push_back(cyc + 1 + 2 * (cs_len + 3));
        end
      end

      // Words.
      while (word_q.size() != 0 && word_q[0].cyc < cyc) begin
        we = word_q.pop_front();
        miss("spi_start_missing", we.cyc);
      end
      if (spi_start) begin
        if (spi_data[15]) b_starts++;
        if (word_q.size() == 0) begin
          unexpected("spi_start_unexpected", int'(spi_data));
        end else begin
          we = word_q.pop_front();
          cmpi("spi_start_cycle", cyc, we.cyc);
          cmpi("spi_data", int'(spi_data), int'(we.word));
        end
      end

      // Ready pulses.
      while (a_q.size() != 0 && a_q[0] < cyc) begin due = a_q.pop_front(); miss("a_ready_missing", due); end
      if (a_ready) begin
        if (a_q.size() == 0) unexpected("a_ready_unexpected", 1);
        else cmpi("a_ready_cycle", cyc, a_q.pop_front());
      end
      while (b_q.size() != 0 && b_q[0] < cyc) begin due = b_q.pop_front(); miss("b_ready_missing", due); end
      if (b_ready) begin
        if (b_q.size() == 0) unexpected("b_ready_unexpected", 1);
        else cmpi("b_ready_cycle", cyc, b_q.pop_front());
      end

      // ldac_n pulses: start cycle and width.
      while (ldac_q.size() != 0 && ldac_q[0] < cyc && ldac_prev) begin
        due = ldac_q.pop_front(); miss("ldac_missing", due);
      end
      if (!ldac_n && ldac_prev) begin
        ldac_lo = 0;
        if (ldac_q.size() == 0) unexpected("ldac_unexpected", 0);
        else cmpi("ldac_start_cycle", cyc, ldac_q.pop_front());
      end
      if (!ldac_n) ldac_lo++;
      if (ldac_n && !ldac_prev) cmpi("ldac_width", ldac_lo, LDAC_CYCLES);
      ldac_prev = ldac_n;

      // Sticky flags, every cycle.
      cmpi("overrun", int'(overrun), int'(exp_ovr));
      cmpi("spi_err", int'(spi_err), int'(exp_err));
      if (ovr_set) exp_ovr = 1'b1;
      else if (clr_flags) exp_ovr = 1'b0;
      if (cyc == err_cyc) exp_err = 1'b1;
      else if (clr_flags) exp_err = 1'b0;
    end

    if (done) begin
      cmpi("words_left",   word_q.size(), 0);
      cmpi("a_ready_left", a_q.size(), 0);
      cmpi("b_ready_left", b_q.size(), 0);
      cmpi("ldac_left",    ldac_q.size(), 0);
      cmpi("reset_in_whi_b_reached", int'(b_rst_done), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    en = 1'b0;
    repeat (160) step();
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
  endtask

  task automatic rand_inputs();
    a_valid = 1'($urandom_range(0, 1));
    b_valid = 1'($urandom_range(0, 1));
    a_data  = 10'($urandom);
    b_data  = 10'($urandom);
  endtask

  initial begin : stim
    int  base;
    bit  found;

    repeat (3) step();
    rst_n = 1'b1;
    // Frame 1: both channels fresh.
    en = 1'b1; a_valid = 1'b1; a_data = 10'h200; b_valid = 1'b1; b_data = 10'h3FF;
    repeat (70) step();
    // Frame 2: B absent, so the previous B word repeats.
    b_valid = 1'b0; a_data = 10'h155;
    repeat (60) step();

    // cs never drops: timeout, no B transfer, no ldac.
    drain();
    cs_never = 1'b1; en = 1'b1;
    repeat (150) step();
    drain();
    cs_never = 1'b0;
    pulse_clr();
    en = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    repeat (120) step();

    // Random traffic with occasional en drops and flag clears.
    for (int f = 0; f < 12; f++) begin
      rand_inputs();
      en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) pulse_clr();
      repeat ($urandom_range(15, 70)) step();
    end

    // en low across three ticks, then back on.
    en = 1'b1;
    repeat (30) step();
    en = 1'b0;
    repeat (3 * DIV) step();
    en = 1'b1; rand_inputs();
    repeat (2 * DIV) step();

    // Frames longer than a tick period: overruns, but frames still complete.
    drain();
    cs_len = 40; en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      rand_inputs();
      repeat (DIV) step();
    end
    drain();
    cs_len = 17;
    pulse_clr();

    // Reset during WHI_B, then resume.
    en = 1'b1; rand_inputs();
    base = b_starts;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (b_starts != base) found = 1'b1;
    end
    if (found) begin
      repeat (4) step();
      rst_n = 1'b0;
      b_rst_done = 1'b1;
      repeat (3) step();
      rst_n = 1'b1;
    end
    a_valid = 1'b0; b_valid = 1'b1; b_data = 10'($urandom);
    repeat (2 * DIV) step();
    rand_inputs();
    repeat (2 * DIV) step();

    drain();
    done = 1'b1;
    repeat (5) step();
  end

endmodule
